evolution_core: RTL and testbench
=================================

EVOLUTION_CORE -- requirements
Module: evolution

Interface
REQ-001 Parameter BLOCK_LEN, default 8: cells per block; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 line_status  input  3*BLOCK_LEN  current block.
  - Bits [BLOCK_LEN-1:0] are the row above.
  - Bits [2*BLOCK_LEN-1:BLOCK_LEN] are the centre row.
  - Bits [3*BLOCK_LEN-1:2*BLOCK_LEN] are the row below.
  - Within each row, bit i is column i of the block; bit 0 is leftmost, 1 = alive.
REQ-005 last_line_status  input  3*BLOCK_LEN  previous (left-adjacent) block of the same three rows, same layout; the caller drives all zeros at the start of a grid row.
REQ-006 now_live  output  BLOCK_LEN  next-generation state of the centre row of the current block, registered.
REQ-007 prev_live_single  output  1  next-generation state of the last column (bit BLOCK_LEN-1) of the previous block's centre row, registered.

Function
REQ-008 The block SHALL apply Conway B3/S23.
  - A cell is alive next if its live-neighbour count is 3.
  - A cell is also alive next if it is currently alive and its count is 2.
  - Otherwise it is dead.
REQ-009 Neighbour count SHALL be the sum of the 8 surrounding cells, range 0..8, computed at least 4 bits wide with no overflow.
REQ-010 Any cell outside the supplied columns or rows SHALL count as dead; grid-edge rows are supplied as zeros by the caller.
REQ-011 For now_live[i], 1 <= i <= BLOCK_LEN-2, neighbours SHALL be columns i-1 and i+1 of the up, centre and down rows of line_status, plus column i of the up and down rows.
REQ-012 For now_live[0], the left neighbour column SHALL be column BLOCK_LEN-1 of the three rows of last_line_status.
REQ-013 For now_live[BLOCK_LEN-1], the right neighbour column SHALL be treated as dead.
  - The caller later overwrites this cell with prev_live_single when the next block arrives.
  - At a row end the dead right column is the correct grid edge.
REQ-014 For prev_live_single, the centre cell SHALL be column BLOCK_LEN-1 of the last_line_status centre row.
  - Left neighbour column: column BLOCK_LEN-2 of last_line_status.
  - Right neighbour column: column 0 of line_status (all three rows).
REQ-015 The next-state logic SHALL be purely combinational from the two inputs.
  - Outputs SHALL be captured on every rising clk edge; latency is exactly 1 cycle.
  - There is no enable and no handshake: new inputs are accepted every cycle.
REQ-016 The block SHALL hold no state other than the output registers.
REQ-017 If inputs change every cycle, each output sample SHALL reflect only the inputs present at the preceding edge.

Reset
REQ-018 While rst is high, now_live and prev_live_single SHALL be 0 immediately, without waiting for a clock edge.
REQ-019 On rst deassertion, outputs SHALL update at the first following rising clk edge from the then-current inputs.
REQ-020 rst asserted mid-stream SHALL discard the pending result; no stale value may appear after release.

Verification (BLOCK_LEN=4, values are per-row nibbles up/centre/down, bit0 leftmost)
REQ-021 Blinker survival:
  - Stimulus: line_status centre=4'b0111, up=down=0; last_line_status=0.
  - Response one cycle later: now_live=4'b0010, prev_live_single=0.
REQ-022 Birth:
  - Stimulus: up=4'b0111, centre=0, down=0; last_line_status=0.
  - Response: now_live=4'b0010.
REQ-023 Block-boundary survival:
  - Stimulus: last_line_status centre=4'b1100; line_status centre=4'b0001; all other rows 0.
  - Response: prev_live_single=1, now_live=4'b0000.
REQ-024 Overcrowding:
  - Stimulus: all 12 bits of line_status=1; last_line_status=0.
  - Response: now_live=4'b0000.
REQ-025 Asynchronous reset:
  - Stimulus: apply the REQ-021 stimulus, clock once, then assert rst between edges.
  - Response: now_live drops to 0 before the next edge.
  - After release plus one edge: now_live=4'b0010 again.
REQ-026 Row-end dead edge:
  - Stimulus: centre=4'b1100, up=4'b1000, down=0; last_line_status=0.
  - Response: now_live[3]=1 (neighbours 2), now_live[2]=1 (neighbours 2), now_live=4'b1100.

Source files
------------

// File: rtl/evolution_core.sv
// Game-of-life next-state block for one slice of three grid rows.
// The centre row of the current block plus the last centre cell of the
// previous block are evolved with Conway B3/S23 and registered.
module evolution_core #(
  parameter int unsigned BLOCK_LEN = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3*BLOCK_LEN-1:0]   line_status,
  input  logic [3*BLOCK_LEN-1:0]   last_line_status,
  output logic [BLOCK_LEN-1:0]     now_live,
  output logic                     prev_live_single
);

  // B3/S23 rule on one cell given its eight neighbours.
  function automatic logic life_rule(input logic alive, input logic [7:0] nb);
    logic [3:0] cnt;
    cnt = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      cnt = cnt + {3'b000, nb[k]};
    end
    return (cnt == 4'd3) || (alive && (cnt == 4'd2));
  endfunction

  // Rows of the current block widened by one column on each side:
  // index 0 is the previous block's last column, index BLOCK_LEN+1 is the
  // not-yet-seen right neighbour, which is treated as dead.
  logic [BLOCK_LEN+1:0] up_x;
  logic [BLOCK_LEN+1:0] cen_x;
  logic [BLOCK_LEN+1:0] dn_x;

  logic [BLOCK_LEN-1:0] now_next;
  logic                 prev_next;
  logic [7:0]           prev_nb;

  // Only the two rightmost columns of the previous block matter here.
  logic                 unused_last_cols;
  assign unused_last_cols = ^last_line_status;

  // Assemble the widened rows from both input blocks.
  always_comb begin
    up_x  = {1'b0, line_status[BLOCK_LEN-1:0],             last_line_status[BLOCK_LEN-1]};
    cen_x = {1'b0, line_status[2*BLOCK_LEN-1:BLOCK_LEN],   last_line_status[2*BLOCK_LEN-1]};
    dn_x  = {1'b0, line_status[3*BLOCK_LEN-1:2*BLOCK_LEN], last_line_status[3*BLOCK_LEN-1]};
  end

  // Next state of every centre cell in the current block.
  always_comb begin
    now_next = '0;
    for (int unsigned i = 0; i < BLOCK_LEN; i++) begin
      now_next[i] = life_rule(cen_x[i+1],
                              {up_x[i +: 3], cen_x[i], cen_x[i+2], dn_x[i +: 3]});
    end
  end

  // Next state of the previous block's last centre cell, now that its
  // right neighbour column (column 0 of this block) is available.
  always_comb begin
    prev_nb = {last_line_status[BLOCK_LEN-2],   last_line_status[BLOCK_LEN-1],   line_status[0],
               last_line_status[2*BLOCK_LEN-2],                                  line_status[BLOCK_LEN],
               last_line_status[3*BLOCK_LEN-2], last_line_status[3*BLOCK_LEN-1], line_status[2*BLOCK_LEN]};
    prev_next = life_rule(last_line_status[2*BLOCK_LEN-1], prev_nb);
  end

  // Output registers: capture every cycle, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now_live         <= '0;
      prev_live_single <= 1'b0;
    end else begin
      now_live         <= now_next;
      prev_live_single <= prev_next;
    end
  end

endmodule

// File: tb/tb_evolution_core.sv
// Directed bench for evolution_core at BLOCK_LEN=4 with hand-computed results.
module tb_evolution_core;

  localparam int unsigned BL = 4;

  logic          clk;
  logic          rst;
  logic [3*BL-1:0] line_status;
  logic [3*BL-1:0] last_line_status;
  logic [BL-1:0] now_live;
  logic          prev_live_single;

  int compared;
  int mismatched;

  evolution_core #(.BLOCK_LEN(BL)) dut (
    .clk              (clk),
    .rst              (rst),
    .line_status      (line_status),
    .last_line_status (last_line_status),
    .now_live         (now_live),
    .prev_live_single (prev_live_single)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_now(input string tag, input logic [BL-1:0] exp);
    compared++;
    assert (now_live === exp) else begin
      mismatched++;
      $error("FAIL %s now_live: got %b expected %b", tag, now_live, exp);
    end
  endtask

  task automatic check_prev(input string tag, input logic exp);
    compared++;
    assert (prev_live_single === exp) else begin
      mismatched++;
      $error("FAIL %s prev_live_single: got %b expected %b", tag, prev_live_single, exp);
    end
  endtask

  task automatic drive(input logic [BL-1:0] up, input logic [BL-1:0] cen, input logic [BL-1:0] dn,
                       input logic [BL-1:0] lup, input logic [BL-1:0] lcen, input logic [BL-1:0] ldn);
    line_status      = {dn, cen, up};
    last_line_status = {ldn, lcen, lup};
  endtask

  // Apply one vector between edges, then check one cycle later.
  task automatic step(input string tag,
                      input logic [BL-1:0] up, input logic [BL-1:0] cen, input logic [BL-1:0] dn,
                      input logic [BL-1:0] lup, input logic [BL-1:0] lcen, input logic [BL-1:0] ldn,
                      input logic [BL-1:0] exp_now, input logic exp_prev);
    @(negedge clk);
    drive(up, cen, dn, lup, lcen, ldn);
    @(posedge clk);
    #1;
    check_now(tag, exp_now);
    check_prev(tag, exp_prev);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    #1;
    check_now("reset_t0", 4'b0000);
    check_prev("reset_t0", 1'b0);

    // Blinker inputs while reset is held across an edge: outputs stay 0.
    drive(4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    check_now("reset_held", 4'b0000);

    // First edge after release captures the current inputs.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_now("release_first_edge", 4'b0010);
    check_prev("release_first_edge", 1'b0);

    // Back-to-back vectors, a new one every cycle.
    step("blinker",     4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    step("birth",       4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    step("boundary",    4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 1'b1);
    step("overcrowd",   4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step("row_end",     4'b1000, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 1'b0);
    step("left_birth",  4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0001, 1'b1);
    step("prev_col_m2", 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0100, 4'b0000, 1'b1);
    step("vertical",    4'b0010, 4'b0100, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 1'b0);
    step("count_four",  4'b0111, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    step("all_zero",    4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Mid-stream asynchronous reset.
    step("pre_reset",   4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    @(negedge clk);
    drive(4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b1;
    #1;
    check_now("async_reset", 4'b0000);
    check_prev("async_reset", 1'b0);
    @(posedge clk);
    #1;
    check_prev("reset_discard", 1'b0);
    @(negedge clk);
    drive(4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    #1;
    check_now("after_release_no_edge", 4'b0000);
    @(posedge clk);
    #1;
    check_now("after_release_edge", 4'b0010);
    check_prev("after_release_edge", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
